// File: rtl/ddr_cmd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_cmd_rr_arbiter
//
// Command arbiter for the DDR AXI controller. It picks one of CH_NUM
// requesters, either by fixed priority (lowest index) or by round-robin. It
// latches the winner's start address and issues a single command request to
// the downstream DDR read or write controller. It then follows that
// controller's busy handshake until the burst group completes. If the
// controller never raises busy while the request is pending, a watchdog
// returns the arbiter to arbitration and emits a one-cycle error pulse.
//
// Ports
//   i_axi_aclk     clock
//   i_rst          synchronous reset, active-high
//   i_init_ack     DDR controller init done (only looked at while idle)
//   i_req          per-channel request
//   i_ready        per-channel data/buffer ready
//   i_addr         packed start addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_grant        one-hot grant / chip select of the channel being served
//   o_cmd_rq       command request, high for every cycle of the start phase
//   o_cmd_addr     latched start address of the granted channel
//   i_ctrl_busy    busy from the downstream controller
//   o_busy         a transaction is in flight
//   o_timeout_err  one-cycle pulse when the start handshake times out
// ---------------------------------------------------------------------------
module ddr_cmd_rr_arbiter #(
    parameter int CH_NUM      = 4,
    parameter int ADDR_WIDTH  = 28,
    parameter int ARB_MODE    = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         i_axi_aclk,
    input  logic                         i_rst,
    input  logic                         i_init_ack,
    input  logic [CH_NUM-1:0]            i_req,
    input  logic [CH_NUM-1:0]            i_ready,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] i_addr,
    output logic [CH_NUM-1:0]            o_grant,
    output logic                         o_cmd_rq,
    output logic [ADDR_WIDTH-1:0]        o_cmd_addr,
    input  logic                         i_ctrl_busy,
    output logic                         o_busy,
    output logic                         o_timeout_err
);

    localparam int IDX_W = $clog2(CH_NUM);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]            state_reg,   state_next;
    logic [CH_NUM-1:0]     grant_reg,   grant_next;
    logic                  cmd_rq_reg,  cmd_rq_next;
    logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
    logic                  busy_reg,    busy_next;
    logic                  err_reg,     err_next;
    logic [IDX_W-1:0]      ptr_reg,     ptr_next;
    logic [CNT_W-1:0]      cnt_reg,     cnt_next;
    logic [IDX_W-1:0]      owner_reg,   owner_next;

    // -----------------------------------------------------------------------
    // Request qualification and address slicing
    // -----------------------------------------------------------------------
    logic [CH_NUM-1:0]     eligible;
    logic [ADDR_WIDTH-1:0] addr_slice [CH_NUM];

    assign eligible = i_req & i_ready;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_slice
            assign addr_slice[gi] = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Search order. Position gi in the search is channel (ptr + gi) mod
    // CH_NUM. In fixed-priority mode the pointer stays at zero, so the
    // search order is simply 0..CH_NUM-1. The wrap is one conditional
    // subtract because ptr + gi never reaches 2*CH_NUM.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] cand_idx [CH_NUM];

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(CH_NUM))
                                ? IDX_W'(sum - (IDX_W+1)'(CH_NUM))
                                : sum[IDX_W-1:0];
        end
    endgenerate

    // The first eligible channel in search order wins.
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!win_valid && eligible[cand_idx[i]]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    logic [CH_NUM-1:0] win_onehot;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    // When a transaction finishes, the next search starts just after the
    // channel that was served. In fixed-priority mode the pointer is pinned
    // at zero.
    logic [IDX_W-1:0] rr_after_owner;

    always_comb begin
        rr_after_owner = '0;
        if (ARB_MODE != 0) begin
            rr_after_owner = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        cmd_rq_next = cmd_rq_reg;
        addr_next   = addr_reg;
        busy_next   = busy_reg;
        err_next    = 1'b0;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        owner_next  = owner_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_init_ack) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                grant_next  = '0;
                cmd_rq_next = 1'b0;
                busy_next   = 1'b0;
                if (win_valid) begin
                    grant_next  = win_onehot;
                    addr_next   = addr_slice[win_idx];
                    owner_next  = win_idx;
                    cnt_next    = '0;
                    cmd_rq_next = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = ST_START;
                end
            end

            ST_START: begin
                // Busy takes precedence over the watchdog on the same cycle.
                if (i_ctrl_busy) begin
                    cmd_rq_next = 1'b0;
                    state_next  = ST_END;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next    = 1'b1;
                    grant_next  = '0;
                    cmd_rq_next = 1'b0;
                    busy_next   = 1'b0;
                    ptr_next    = rr_after_owner;
                    state_next  = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_END: begin
                if (!i_ctrl_busy) begin
                    grant_next = '0;
                    busy_next  = 1'b0;
                    ptr_next   = rr_after_owner;
                    state_next = ST_WAIT;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_axi_aclk) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            cmd_rq_reg <= 1'b0;
            addr_reg   <= '0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            owner_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            cmd_rq_reg <= cmd_rq_next;
            addr_reg   <= addr_next;
            busy_reg   <= busy_next;
            err_reg    <= err_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
        end
    end

    assign o_grant       = grant_reg;
    assign o_cmd_rq      = cmd_rq_reg;
    assign o_cmd_addr    = addr_reg;
    assign o_busy        = busy_reg;
    assign o_timeout_err = err_reg;

endmodule

// File: doc/ddr_cmd_rr_arbiter.md
Name: ddr_cmd_rr_arbiter

Overview:
- Parametrised command arbiter for the DDR AXI controller.
- Selects one of CH_NUM requesters using round-robin or fixed priority, and latches the winner's start address.
- Drives a one-burst-group command request to a downstream DDR read or write controller, then tracks that controller's busy handshake.
- Adds a start-handshake watchdog. Usable for either the read path or the write path.

Parameters:
CH_NUM, 4, number of requesting channels (>=2)
ADDR_WIDTH, 28, DDR controller address width
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT_CYC, 64, max cycles in START waiting for i_ctrl_busy rise (>=2)

Ports:
i_axi_aclk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_init_ack  in  1  DDRC init done
i_req  in  CH_NUM  per-channel request
i_ready  in  CH_NUM  per-channel data/buffer ready
i_addr  in  CH_NUM*ADDR_WIDTH  packed start addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
o_grant  out  CH_NUM  one-hot grant / chip select
o_cmd_rq  out  1  command request to DDR rd/wr controller
o_cmd_addr  out  ADDR_WIDTH  latched start address of granted channel
i_ctrl_busy  in  1  busy from downstream controller
o_busy  out  1  arbiter has a transaction in flight
o_timeout_err  out  1  one-cycle pulse on start-handshake timeout

Behaviour:
- Reset, sampled on i_axi_aclk while i_rst=1:
  - state=IDLE; o_grant=0, o_cmd_rq=0, o_cmd_addr=0, o_busy=0, o_timeout_err=0.
  - RR pointer=0, timeout counter=0.
  - Reset asserted mid-transaction aborts it at the next edge; no err pulse is generated.
- eligible = i_req & i_ready (combinational).
- State machine, all outputs registered:
  - IDLE: go to WAIT when i_init_ack=1. i_init_ack is only sampled in IDLE.
  - WAIT: if eligible!=0, at the same edge:
    - latch winner into o_grant (one-hot);
    - latch o_cmd_addr from the winner's slice;
    - clear counter; go to START.
    - Otherwise stay; o_grant=0.
  - START: o_cmd_rq=1 and o_busy=1 for every cycle in START.
    - i_ctrl_busy=1 → END.
    - Else if counter==TIMEOUT_CYC-1 → WAIT, o_timeout_err=1 for one cycle, o_grant cleared, RR pointer = winner+1 (mod CH_NUM).
    - Else counter+1.
  - END: o_cmd_rq=0, o_busy=1, o_grant held.
    - i_ctrl_busy=0 → WAIT, o_grant cleared, RR pointer = winner+1 (mod CH_NUM).
- Latency:
  - eligible sampled at edge k in WAIT → o_grant, o_cmd_addr and o_cmd_rq valid after edge k.
  - Minimum gap between back-to-back grants is one WAIT cycle (grant low for 1 cycle).
- Arbitration:
  - ARB_MODE=0: lowest set index of eligible wins. Pointer unused and held at 0.
  - ARB_MODE=1: first set bit at index >= pointer wins, wrapping to index 0. Pointer width = clog2(CH_NUM); wraps CH_NUM-1 → 0.
- Request/address changes:
  - Inputs changing after the grant edge have no effect; address and grant stay latched until return to WAIT.
  - A channel dropping i_req while granted does not abort the transaction.
- Widths:
  - Counter width = clog2(TIMEOUT_CYC); it never exceeds TIMEOUT_CYC-1.
  - Address slices are selected by index multiplication; no arithmetic on addresses.
- Timing boundary: i_ctrl_busy=1 on the same cycle the counter reaches TIMEOUT_CYC-1 → END; busy wins, no error.

Test Plan:
1. i_rst=1 for 3 cycles with i_req=4'hF, i_ready=4'hF; release with i_init_ack=0 for 10 cycles → all outputs 0, no grant. Then raise i_init_ack → o_grant=4'b0001 two cycles later.
2. ARB_MODE=1, CH_NUM=4, i_req=i_ready=4'hF continuously, DDRC model busy 1 cycle after o_cmd_rq for 8 cycles → o_grant sequence 0001, 0010, 0100, 1000, 0001; o_cmd_addr matches each slice (0x100, 0x200, 0x300, 0x400).
3. ARB_MODE=0, same stimulus → o_grant always 0001. Then drop i_ready[0] → next grant 0010.
4. ARB_MODE=1, pointer=3 after grant of ch2, eligible=4'b0011 → grant ch0, then ch1 (wrap-around).
5. TIMEOUT_CYC=16, i_ctrl_busy tied 0, ch1 eligible → o_cmd_rq high exactly 16 cycles, o_timeout_err pulses 1 cycle, o_grant=0, o_busy=0, next grant goes to ch2 if eligible, else ch1.
6. Assert i_rst during END with o_grant=0100 → next edge: all outputs 0, state IDLE, pointer 0, no err pulse.
